// File: rtl/color_scan_sequencer.sv
// Colour scan sequencer for a TCS3200-style sensor.
// Each frame steps the S2/S3 filter selects through red, blue, clear and green.
// For each filter it waits out a settle interval, counts synchronised rising
// edges of freq_in over a gate window, and keeps the count in a shadow register.
// When all four channels are done it classifies the dominant colour. The
// shadows, the colour code and a one-cycle sample_valid pulse are then
// published together on one edge.
//
// Output qualifier: sample_valid is a one-cycle strobe with no ready/backpressure.
// The four counts and color_code change only on the edge that raises
// sample_valid, and they hold their values until the next strobe.
module color_scan_sequencer #(
  parameter int SETTLE_CYCLES = 100000,
  parameter int GATE_CYCLES   = 12500000,
  parameter int CNT_W         = 25,
  parameter int CLEAR_MIN     = 1000,
  parameter int RED_MIN       = 1800,
  parameter int GREEN_MIN     = 2500,
  parameter int BLUE_MIN      = 1500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             freq_in,
  output logic             select2,
  output logic             select3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [1:0]       color_code,
  output logic             sample_valid,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  // Thresholds are assumed to fit in CNT_W bits.
  localparam logic [CNT_W-1:0] CLEAR_TH = CNT_W'(CLEAR_MIN);
  localparam logic [CNT_W-1:0] RED_TH   = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] GREEN_TH = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] BLUE_TH  = CNT_W'(BLUE_MIN);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_GATE     = 3'd2,
    ST_STORE    = 3'd3,
    ST_CLASSIFY = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;          // channel index; its bits are the filter selects
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] shadow_q [4];
  logic [CNT_W-1:0] shadow_d [4];
  logic [CNT_W-1:0] red_q, red_d, blue_q, blue_d, clear_q, clear_d, green_q, green_d;
  logic [1:0]       code_q, code_d, class_code;
  logic             sv_q, sv_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             edge_det;

  // Two-flop synchroniser for the asynchronous sensor output, plus edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= freq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~prev_q;

  // Classification from the shadows; a tie or a sub-threshold winner holds the old code.
  always_comb begin
    class_code = code_q;
    if (shadow_q[2] < CLEAR_TH) begin
      class_code = 2'd0;
    end else if ((shadow_q[0] > shadow_q[1]) && (shadow_q[0] > shadow_q[3])) begin
      if (shadow_q[0] >= RED_TH) class_code = 2'd1;
    end else if ((shadow_q[3] > shadow_q[0]) && (shadow_q[3] > shadow_q[1])) begin
      if (shadow_q[3] >= GREEN_TH) class_code = 2'd2;
    end else if ((shadow_q[1] > shadow_q[0]) && (shadow_q[1] > shadow_q[3])) begin
      if (shadow_q[1] >= BLUE_TH) class_code = 2'd3;
    end
  end

  // Next-state and datapath updates for the scan FSM.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tmr_d      = tmr_q;
    edge_cnt_d = edge_cnt_q;
    shadow_d   = shadow_q;
    red_d      = red_q;
    blue_d     = blue_q;
    clear_d    = clear_q;
    green_d    = green_q;
    code_d     = code_q;
    sv_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SETTLE;
          ch_d    = 2'd0;
          tmr_d   = '0;
        end
      end
      ST_SETTLE: begin
        edge_cnt_d = '0;
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_GATE: begin
        if (edge_det && (edge_cnt_q != CNT_MAX)) edge_cnt_d = edge_cnt_q + 1'b1;
        if (tmr_q == GATE_LAST) begin
          state_d = ST_STORE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_STORE: begin
        shadow_d[ch_q] = edge_cnt_q;
        if (ch_q != 2'd3) begin
          ch_d    = ch_q + 2'd1;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: begin
        red_d   = shadow_q[0];
        blue_d  = shadow_q[1];
        clear_d = shadow_q[2];
        green_d = shadow_q[3];
        code_d  = class_code;
        sv_d    = 1'b1;
        ch_d    = 2'd0;
        tmr_d   = '0;
        state_d = enable ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, shadows and published outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= 2'd0;
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      shadow_q   <= '{default: '0};
      red_q      <= '0;
      blue_q     <= '0;
      clear_q    <= '0;
      green_q    <= '0;
      code_q     <= 2'd0;
      sv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      tmr_q      <= tmr_d;
      edge_cnt_q <= edge_cnt_d;
      shadow_q   <= shadow_d;
      red_q      <= red_d;
      blue_q     <= blue_d;
      clear_q    <= clear_d;
      green_q    <= green_d;
      code_q     <= code_d;
      sv_q       <= sv_d;
    end
  end

  assign select2      = ch_q[1];
  assign select3      = ch_q[0];
  assign red_cnt      = red_q;
  assign blue_cnt     = blue_q;
  assign clear_cnt    = clear_q;
  assign green_cnt    = green_q;
  assign color_code   = code_q;
  assign sample_valid = sv_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Bench for color_scan_sequencer: a sensor model that answers the filter selects,
// frame configurations that are pushed to an expected queue, and a monitor that
// pops an entry on every sample_valid.
module tb_color_scan_sequencer;

  localparam int S  = 4;
  localparam int G  = 20;
  localparam int CW = 25;
  localparam int EW = 4 * CW + 2;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_GATE     = 3'd2;
  localparam logic [2:0] ST_CLASSIFY = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic freq_in = 1'b0;
  always #5 clk = ~clk;

  logic          select2, select3, sample_valid, busy;
  logic [CW-1:0] red_cnt, blue_cnt, clear_cnt, green_cnt;
  logic [1:0]    color_code;
  logic [2:0]    dbg_state;

  logic       s_sel2, s_sel3, s_sv, s_busy;
  logic [2:0] s_red, s_blue, s_clear, s_green, s_dbg;
  logic [1:0] s_code;

  color_scan_sequencer #(
    .SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(CW),
    .CLEAR_MIN(3), .RED_MIN(2), .GREEN_MIN(2), .BLUE_MIN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq_in(freq_in),
    .select2(select2), .select3(select3),
    .red_cnt(red_cnt), .blue_cnt(blue_cnt), .clear_cnt(clear_cnt), .green_cnt(green_cnt),
    .color_code(color_code), .sample_valid(sample_valid), .busy(busy), .dbg_state(dbg_state)
  );

  // Narrow-count copy driven by the same stimulus, used for saturation.
  color_scan_sequencer #(
    .SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(3),
    .CLEAR_MIN(3), .RED_MIN(2), .GREEN_MIN(2), .BLUE_MIN(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq_in(freq_in),
    .select2(s_sel2), .select3(s_sel3),
    .red_cnt(s_red), .blue_cnt(s_blue), .clear_cnt(s_clear), .green_cnt(s_green),
    .color_code(s_code), .sample_valid(s_sv), .busy(s_busy), .dbg_state(s_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- sensor model ----------------
  // Period per filter index {S2,S3}; 0 means a silent output. The wave restarts
  // high whenever the sequencer enters SETTLE, so rising edges land on phases
  // that are multiples of the period.
  int per [4] = '{0, 0, 0, 0};
  int ph = 0;
  int cur_p = 0;
  logic [2:0] prev_st = 3'd0;

  always @(posedge clk) begin
    #1;
    if (dbg_state == ST_SETTLE && prev_st != ST_SETTLE) begin
      ph = 0;
      cur_p = per[{select2, select3}];
    end else begin
      ph = ph + 1;
    end
    prev_st = dbg_state;
    freq_in = (cur_p == 0) ? 1'b0 : ((ph % cur_p) < (cur_p / 2));
  end

  // ---------------- reference model ----------------
  // Synchroniser plus edge detector lag by two cycles, so the gate cycles
  // S..S+G-1 see rising edges generated at phases S-2..S+G-3.
  function automatic int model_cnt(input int p, input int w);
    int n = 0;
    if (p > 0)
      for (int a = S - 2; a <= S + G - 3; a++)
        if (a % p == 0) n++;
    if (n > (1 << w) - 1) n = (1 << w) - 1;
    return n;
  endfunction

  function automatic logic [1:0] classify(input logic [CW-1:0] r, b, c, g, input logic [1:0] prev);
    if (c < 3) return 2'd0;
    if (r > b && r > g) return (r >= 2) ? 2'd1 : prev;
    if (g > r && g > b) return (g >= 2) ? 2'd2 : prev;
    if (b > r && b > g) return (b >= 2) ? 2'd3 : prev;
    return prev;
  endfunction

  logic [EW-1:0] exp_q [$];
  logic [1:0] model_code = 2'd0;

  task automatic push_exp();
    logic [CW-1:0] r, b, c, g;
    logic [1:0] code;
    r = CW'(model_cnt(per[0], CW));
    b = CW'(model_cnt(per[1], CW));
    c = CW'(model_cnt(per[2], CW));
    g = CW'(model_cnt(per[3], CW));
    code = classify(r, b, c, g, model_code);
    model_code = code;
    exp_q.push_back({r, b, c, g, code});
  endtask

  task automatic set_per(input int pr, input int pb, input int pc, input int pg);
    per[0] = pr; per[1] = pb; per[2] = pc; per[3] = pg;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] last_out = '0;
  logic sv_prev = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] cur, e;
    cur = {red_cnt, blue_cnt, clear_cnt, green_cnt, color_code};
    if (!rst_n) begin
      last_out = cur;
      sv_prev = 1'b0;
    end else if (sample_valid) begin
      check("sv_width", sv_prev, 1'b0);
      check("sv_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("red_cnt", red_cnt, e[4*CW+1:3*CW+2]);
        check("blue_cnt", blue_cnt, e[3*CW+1:2*CW+2]);
        check("clear_cnt", clear_cnt, e[2*CW+1:CW+2]);
        check("green_cnt", green_cnt, e[CW+1:2]);
        check("color_code", color_code, e[1:0]);
      end
      last_out = cur;
      sv_prev = 1'b1;
    end else begin
      check("stable_outputs", cur, last_out);
      sv_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input string tag, input logic [2:0] st, input logic [1:0] sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dbg_state == st && {select2, select3} == sel) && n < 400);
    check(tag, {dbg_state, select2, select3}, {st, sel});
  endtask

  task automatic wait_sv(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 400);
    check(tag, sample_valid, 1'b1);
  endtask

  // Load the next frame's sensor periods while the current frame classifies.
  task automatic frame_at_classify(input int pr, input int pb, input int pc, input int pg,
                                   input logic en);
    wait_state("reach_classify", ST_CLASSIFY, 2'b11);
    set_per(pr, pb, pc, pg);
    push_exp();
    enable = en;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int sel_cnt [4];
    int pulses;
    int sat_exp;

    repeat (3) @(negedge clk);
    check("rst_counts", {red_cnt, blue_cnt, clear_cnt, green_cnt}, '0);
    check("rst_code", color_code, 2'd0);
    check("rst_flags", {sample_valid, busy, select2, select3}, 4'b0000);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: silent sensor, frame timing and select schedule.
    set_per(0, 0, 0, 0);
    push_exp();
    enable = 1'b1;
    @(posedge clk);
    cyc = 0;
    sel_cnt = '{0, 0, 0, 0};
    while (cyc < 300) begin
      @(negedge clk);
      if (sample_valid) break;
      if (cyc == 0) check("busy_running", busy, 1'b1);
      sel_cnt[{select2, select3}]++;
      if (dbg_state == ST_CLASSIFY) begin
        set_per(4, 4, 4, 4);
        push_exp();
      end
      cyc++;
    end
    check("frame_len", cyc, 101);
    check("sel_red_len", sel_cnt[0], 25);
    check("sel_blue_len", sel_cnt[1], 25);
    check("sel_clear_len", sel_cnt[2], 25);
    // green selects stay through the CLASSIFY cycle
    check("sel_green_len", sel_cnt[3], 26);

    // Frames 3..6 with frame 2 (equal periods, tie) already running.
    frame_at_classify(4, 10, 2, 20, 1'b1);
    frame_at_classify(20, 10, 2, 4, 1'b1);
    frame_at_classify(20, 10, 40, 4, 1'b1);
    frame_at_classify(2, 2, 2, 2, 1'b1);
    sat_exp = model_cnt(2, 3);
    frame_at_classify(4, 10, 2, 20, 1'b1);
    wait_sv("sv_frame6");
    check("sat_red", s_red, sat_exp[2:0]);
    check("sat_blue", s_blue, sat_exp[2:0]);
    check("sat_clear", s_clear, sat_exp[2:0]);
    check("sat_green", s_green, sat_exp[2:0]);

    // Frame 7: drop enable in ch1 GATE; the frame still completes.
    wait_state("reach_ch1_gate", ST_GATE, 2'b01);
    enable = 1'b0;
    wait_sv("sv_frame7");
    check("end_idle", dbg_state, ST_IDLE);
    check("end_selects", {select2, select3}, 2'b00);
    check("end_busy", busy, 1'b0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    check("no_extra_sv", pulses, 0);

    // Frame 8: reset during ch2 SETTLE aborts the frame.
    set_per(4, 4, 4, 4);
    enable = 1'b1;
    wait_state("reach_ch2_settle", ST_SETTLE, 2'b10);
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_counts", {red_cnt, blue_cnt, clear_cnt, green_cnt}, '0);
    check("midrst_code", color_code, 2'd0);
    check("midrst_flags", {sample_valid, busy, select2, select3}, 4'b0000);
    check("midrst_state", dbg_state, ST_IDLE);
    model_code = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    check("no_sv_after_rst", pulses, 0);

    // Frame 9: a clean frame after reset.
    set_per(4, 10, 2, 20);
    push_exp();
    enable = 1'b1;
    wait_state("reach_classify_f9", ST_CLASSIFY, 2'b11);
    enable = 1'b0;
    wait_sv("sv_frame9");
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/color_scan_sequencer.md
Name: color_scan_sequencer

Overview:
- Controller for the TCS3200-style colour sensor datapath. Drives the S2/S3 filter selects through a fixed red, blue, clear, green schedule.
- For each filter it waits a settle interval, then counts sensor output edges over a fixed gate window, and latches the four channel counts.
- Classifies the dominant colour and emits a one-cycle frame strobe. Feeds the rover mode FSM that selects motor/PWM states.

Parameters:
- SETTLE_CYCLES, 100000, clock cycles held after a filter change before counting starts (>=1)
- GATE_CYCLES, 12500000, clock cycles of the edge-count window per channel (>=1)
- CNT_W, 25, width of each channel count
- CLEAR_MIN, 1000, minimum clear count for a valid classification (too dark below this)
- RED_MIN, 1800, minimum red count for a red decision
- GREEN_MIN, 2500, minimum green count for a green decision
- BLUE_MIN, 1500, minimum blue count for a blue decision

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run continuous scan frames while high
- freq_in  in  1  sensor frequency output, asynchronous to clk
- select2  out  1  filter select S2
- select3  out  1  filter select S3
- red_cnt  out  CNT_W  latched red count
- blue_cnt  out  CNT_W  latched blue count
- clear_cnt  out  CNT_W  latched clear count
- green_cnt  out  CNT_W  latched green count
- color_code  out  2  0 none, 1 red, 2 green, 3 blue
- sample_valid  out  1  one-cycle pulse when all counts and color_code update
- busy  out  1  high whenever not in IDLE

Behaviour:
- Reset (rst_n low at a clk edge), from any state including mid-frame:
  - state IDLE; select2 = select3 = 0
  - all counts = 0; color_code = 0; sample_valid = 0; busy = 0
  - synchroniser and edge detector = 0; internal counters = 0
- freq_in input handling:
  - passes through a 2-flop synchroniser
  - a rising edge is detected when the synced value is 1 and the previous synced value was 0
- Filter schedule, with index ch from 0 to 3:
  - ch0 red: S2=0, S3=0
  - ch1 blue: S2=0, S3=1
  - ch2 clear: S2=1, S3=0
  - ch3 green: S2=1, S3=1
  - select2/select3 are registered and change on the same edge the FSM enters SETTLE for that channel.
- States:
  - IDLE:
    - If enable=1, go to SETTLE with ch=0 and load the red selects.
    - Otherwise stay.
  - SETTLE:
    - Lasts exactly SETTLE_CYCLES cycles.
    - Edges are ignored; the edge counter is cleared.
    - Then go to GATE.
  - GATE:
    - Lasts exactly GATE_CYCLES cycles.
    - Every detected edge in any GATE cycle, including the last, increments the edge counter.
    - The edge counter saturates at 2^CNT_W-1 and never wraps.
    - Then go to STORE.
  - STORE (1 cycle):
    - Write the edge counter to the shadow register for ch.
    - If ch<3: ch+1, load the next selects, go to SETTLE.
    - If ch=3: go to CLASSIFY.
  - CLASSIFY (1 cycle): compute a new code from the shadow registers.
    - If clear < CLEAR_MIN, the code is 0.
    - Otherwise the winner is the channel whose count is strictly greater than both other colour counts and at least its own MIN. Codes: red 1, green 2, blue 3.
    - A tie for the maximum, or a winner below its MIN, gives a hold: the code keeps its previous value.
  - After CLASSIFY:
    - On the next edge, copy the shadows to red_cnt/blue_cnt/clear_cnt/green_cnt, update color_code, and pulse sample_valid for exactly 1 cycle.
    - If enable=1, go to SETTLE with ch=0 (red selects) in that same edge. Otherwise go to IDLE with selects = 0.
- Published outputs are stable between sample_valid pulses. A partial frame is never visible.
- enable is sampled only in IDLE and at frame end. Deasserting enable mid-frame completes the current frame, including sample_valid.
- Frame period from entering SETTLE(ch0) to the sample_valid cycle is 4*(SETTLE_CYCLES+GATE_CYCLES+1)+1 cycles.
- Count arithmetic is unsigned throughout; comparisons use full CNT_W width.

Test Plan:
- Parameters for all scenarios: SETTLE_CYCLES=4, GATE_CYCLES=20, CLEAR_MIN=3, RED_MIN=GREEN_MIN=BLUE_MIN=2.
- Reset then enable=1 with freq_in idle:
  - select pairs (0,0),(0,1),(1,0),(1,1) each appear for 4+20+1 cycles
  - sample_valid pulses at cycle 101 after leaving IDLE
  - all counts 0, color_code 0
- freq_in square wave with 4-cycle period for all channels:
  - each count = 5
  - clear >= 3 but three-way tie, so color_code holds 0
- Channel-dependent stimulus (red period 4, blue period 10, clear period 2, green period 20):
  - red_cnt=5, blue_cnt=2, clear_cnt=10, green_cnt=1
  - color_code=1
- Then red period 20, green period 4, blue period 10:
  - next frame gives color_code=2 with one sample_valid
  - then make clear period 40: clear_cnt=0, color_code=0
- enable dropped during ch1 GATE:
  - frame completes, sample_valid pulses once, FSM enters IDLE with selects (0,0)
  - rst_n low during ch2 SETTLE instead: all outputs at reset values next cycle, no sample_valid
- CNT_W=3 with freq_in period 2 (10 edges):
  - each count saturates at 7, no wrap
